// File: rtl/pipeline_cpu.sv
// pipeline_cpu: five-stage in-order MIPS-subset core (IF, ID, EX, MEM, WB).
// It holds its own instruction memory, data memory and register file.
// It has load-use stall detection, EX operand forwarding, and branch/jump
// resolution in ID with a one-slot flush.
// Ports:
//   clk_i   - single clock, all state updates on the rising edge
//   rst_i   - synchronous active-high reset (pipeline and PC only, not memories)
//   start_i - run enable; PC advances only while high

package pipeline_cpu_pkg;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_e;
endpackage

// Program counter register with load enable.
module pc_reg (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_o
);
    always_ff @(posedge clk_i) begin
        if (rst_i)     pc_o <= '0;
        else if (en_i) pc_o <= pc_i;
    end
endmodule

// Word-addressed instruction memory; write port only used for loading.
module instr_mem #(
    parameter int unsigned WORDS = 256
) (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] instr_o
);
    localparam int unsigned AW = $clog2(WORDS);
    logic [31:0]   memory [0:WORDS-1];
    logic [AW-1:0] idx;
    logic          unused_addr;

    assign idx         = addr_i[AW+1:2];
    assign unused_addr = ^{addr_i[31:AW+2], addr_i[1:0]};
    assign instr_o     = memory[idx];

    always_ff @(posedge clk_i) begin
        if (we_i) memory[idx] <= wdata_i;
    end
endmodule

// Two-read/one-write register file; r0 is hardwired to zero and a same-cycle
// write is bypassed to the read ports.
module reg_file #(
    parameter int unsigned NREGS = 32
) (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  ra_i,
    input  logic [4:0]  rb_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rda_o,
    output logic [31:0] rdb_o
);
    logic [31:0] register [0:NREGS-1];

    always_ff @(posedge clk_i) begin
        if (we_i && wa_i != 5'd0) register[wa_i] <= wd_i;
    end

    always_comb begin
        rda_o = register[ra_i];
        rdb_o = register[rb_i];
        if (we_i && wa_i == ra_i) rda_o = wd_i;
        if (we_i && wa_i == rb_i) rdb_o = wd_i;
        if (ra_i == 5'd0) rda_o = '0;
        if (rb_i == 5'd0) rdb_o = '0;
    end
endmodule

// Little-endian byte memory; word access, address wraps modulo depth.
module data_mem #(
    parameter int unsigned BYTES = 32
) (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    localparam int unsigned AW = $clog2(BYTES);
    logic [7:0]    memory [0:BYTES-1];
    logic [AW-1:0] a0, a1, a2, a3;
    logic          unused_addr;

    assign a0          = {addr_i[AW-1:2], 2'd0};
    assign a1          = {addr_i[AW-1:2], 2'd1};
    assign a2          = {addr_i[AW-1:2], 2'd2};
    assign a3          = {addr_i[AW-1:2], 2'd3};
    assign unused_addr = ^{addr_i[31:AW], addr_i[1:0]};
    assign rdata_o     = {memory[a3], memory[a2], memory[a1], memory[a0]};

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            memory[a0] <= wdata_i[7:0];
            memory[a1] <= wdata_i[15:8];
            memory[a2] <= wdata_i[23:16];
            memory[a3] <= wdata_i[31:24];
        end
    end
endmodule

// Load-use hazard: lw in EX whose rt feeds the instruction in ID.
module hazard_unit (
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    output logic       data_o
);
    assign data_o = ex_mem_read_i && (ex_rt_i == id_rs_i || ex_rt_i == id_rt_i);
endmodule

// Main decoder; anything not recognised decodes to a NOP.
module control_unit
    import pipeline_cpu_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic       reg_write_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_o,
    output logic       reg_dst_o,
    output alu_op_e    alu_op_o,
    output logic       IsBranch_o,
    output logic       IsJump_o
);
    always_comb begin
        reg_write_o  = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_src_o    = 1'b0;
        reg_dst_o    = 1'b0;
        alu_op_o     = ALU_ADD;
        IsBranch_o   = 1'b0;
        IsJump_o     = 1'b0;
        case (op_i)
            6'h00: begin
                reg_dst_o = 1'b1;
                case (funct_i)
                    6'h20: reg_write_o = 1'b1;
                    6'h22: begin reg_write_o = 1'b1; alu_op_o = ALU_SUB; end
                    6'h24: begin reg_write_o = 1'b1; alu_op_o = ALU_AND; end
                    6'h25: begin reg_write_o = 1'b1; alu_op_o = ALU_OR;  end
                    6'h18: begin reg_write_o = 1'b1; alu_op_o = ALU_MUL; end
                    default: reg_write_o = 1'b0;
                endcase
            end
            6'h08: begin reg_write_o = 1'b1; alu_src_o = 1'b1; end
            6'h23: begin
                reg_write_o  = 1'b1;
                mem_read_o   = 1'b1;
                mem_to_reg_o = 1'b1;
                alu_src_o    = 1'b1;
            end
            6'h2B: begin mem_write_o = 1'b1; alu_src_o = 1'b1; end
            6'h04: IsBranch_o = 1'b1;
            6'h02: IsJump_o   = 1'b1;
            default: reg_write_o = 1'b0;
        endcase
    end
endmodule

module pipeline_cpu
    import pipeline_cpu_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned DMEM_BYTES = 32,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i
);
    logic [31:0] pc, pc4, pc_next, if_instr;
    logic        stall, flush;
    logic [31:0] if_id_instr, if_id_pc4;

    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_imm, id_rs_val, id_rt_val, id_target;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        id_alu_src, id_reg_dst, id_is_branch, id_is_jump;
    alu_op_e     id_alu_op;
    logic        unused_shamt;

    logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src;
    alu_op_e     id_ex_alu_op;
    logic [31:0] id_ex_rs_val, id_ex_rt_val, id_ex_imm;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dest;
    logic [31:0] ex_a, ex_b_reg, ex_b, ex_alu;

    logic        ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write, ex_mem_mem_to_reg;
    logic [31:0] ex_mem_alu, ex_mem_store, mem_rdata;
    logic [4:0]  ex_mem_dest;

    logic        mem_wb_reg_write, mem_wb_mem_to_reg;
    logic [31:0] mem_wb_alu, mem_wb_load, wb_data;
    logic [4:0]  mem_wb_dest;

    // IF: PC update and fetch
    assign pc4     = pc + 32'd4;
    assign pc_next = flush ? id_target : pc4;

    pc_reg PC (.clk_i(clk_i), .rst_i(rst_i), .en_i(start_i && !stall), .pc_i(pc_next), .pc_o(pc));

    instr_mem #(.WORDS(IMEM_WORDS)) Instruction_Memory (
        .clk_i(clk_i), .we_i(1'b0), .addr_i(pc), .wdata_i(32'd0), .instr_o(if_instr));

    // IF/ID: hold on stall, NOP on flush or while not running
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if_id_instr <= '0;
            if_id_pc4   <= '0;
        end else if (!stall) begin
            if (flush || !start_i) begin
                if_id_instr <= '0;
                if_id_pc4   <= '0;
            end else begin
                if_id_instr <= if_instr;
                if_id_pc4   <= pc4;
            end
        end
    end

    // ID: decode, register read, branch/jump resolution
    assign id_rs        = if_id_instr[25:21];
    assign id_rt        = if_id_instr[20:16];
    assign id_rd        = if_id_instr[15:11];
    assign id_imm       = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
    assign unused_shamt = ^if_id_instr[10:6];

    control_unit Control (
        .op_i(if_id_instr[31:26]), .funct_i(if_id_instr[5:0]),
        .reg_write_o(id_reg_write), .mem_read_o(id_mem_read), .mem_write_o(id_mem_write),
        .mem_to_reg_o(id_mem_to_reg), .alu_src_o(id_alu_src), .reg_dst_o(id_reg_dst),
        .alu_op_o(id_alu_op), .IsBranch_o(id_is_branch), .IsJump_o(id_is_jump));

    reg_file #(.NREGS(NUM_REGS)) Registers (
        .clk_i(clk_i), .we_i(mem_wb_reg_write), .ra_i(id_rs), .rb_i(id_rt),
        .wa_i(mem_wb_dest), .wd_i(wb_data), .rda_o(id_rs_val), .rdb_o(id_rt_val));

    hazard_unit HD_Unit (
        .ex_mem_read_i(id_ex_mem_read), .ex_rt_i(id_ex_rt),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .data_o(stall));

    assign id_target = id_is_jump ? {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}
                                  : if_id_pc4 + {id_imm[29:0], 2'b00};
    // a stall defers the redirect; the branch is re-evaluated next cycle
    assign flush = ((id_is_branch && id_rs_val == id_rt_val) || id_is_jump) && !stall;

    // ID/EX: bubble on stall
    always_ff @(posedge clk_i) begin
        if (rst_i || stall) begin
            id_ex_reg_write  <= 1'b0;
            id_ex_mem_read   <= 1'b0;
            id_ex_mem_write  <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_alu_src    <= 1'b0;
            id_ex_alu_op     <= ALU_ADD;
            id_ex_rs_val     <= '0;
            id_ex_rt_val     <= '0;
            id_ex_imm        <= '0;
            id_ex_rs         <= '0;
            id_ex_rt         <= '0;
            id_ex_dest       <= '0;
        end else begin
            id_ex_reg_write  <= id_reg_write;
            id_ex_mem_read   <= id_mem_read;
            id_ex_mem_write  <= id_mem_write;
            id_ex_mem_to_reg <= id_mem_to_reg;
            id_ex_alu_src    <= id_alu_src;
            id_ex_alu_op     <= id_alu_op;
            id_ex_rs_val     <= id_rs_val;
            id_ex_rt_val     <= id_rt_val;
            id_ex_imm        <= id_imm;
            id_ex_rs         <= id_rs;
            id_ex_rt         <= id_rt;
            id_ex_dest       <= id_reg_dst ? id_rd : id_rt;
        end
    end

    // EX: operand forwarding, EX/MEM ahead of MEM/WB
    always_comb begin
        ex_a     = id_ex_rs_val;
        ex_b_reg = id_ex_rt_val;
        if (ex_mem_reg_write && ex_mem_dest != 5'd0 && ex_mem_dest == id_ex_rs)
            ex_a = ex_mem_alu;
        else if (mem_wb_reg_write && mem_wb_dest != 5'd0 && mem_wb_dest == id_ex_rs)
            ex_a = wb_data;
        if (ex_mem_reg_write && ex_mem_dest != 5'd0 && ex_mem_dest == id_ex_rt)
            ex_b_reg = ex_mem_alu;
        else if (mem_wb_reg_write && mem_wb_dest != 5'd0 && mem_wb_dest == id_ex_rt)
            ex_b_reg = wb_data;
    end

    assign ex_b = id_ex_alu_src ? id_ex_imm : ex_b_reg;

    // EX: ALU
    always_comb begin
        case (id_ex_alu_op)
            ALU_SUB: ex_alu = ex_a - ex_b;
            ALU_AND: ex_alu = ex_a & ex_b;
            ALU_OR:  ex_alu = ex_a | ex_b;
            ALU_MUL: ex_alu = ex_a * ex_b;
            default: ex_alu = ex_a + ex_b;
        endcase
    end

    // EX/MEM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_mem_reg_write  <= 1'b0;
            ex_mem_mem_read   <= 1'b0;
            ex_mem_mem_write  <= 1'b0;
            ex_mem_mem_to_reg <= 1'b0;
            ex_mem_alu        <= '0;
            ex_mem_store      <= '0;
            ex_mem_dest       <= '0;
        end else begin
            ex_mem_reg_write  <= id_ex_reg_write;
            ex_mem_mem_read   <= id_ex_mem_read;
            ex_mem_mem_write  <= id_ex_mem_write;
            ex_mem_mem_to_reg <= id_ex_mem_to_reg;
            ex_mem_alu        <= ex_alu;
            ex_mem_store      <= ex_b_reg;
            ex_mem_dest       <= id_ex_dest;
        end
    end

    // MEM: data memory access
    data_mem #(.BYTES(DMEM_BYTES)) Data_Memory (
        .clk_i(clk_i), .we_i(ex_mem_mem_write), .addr_i(ex_mem_alu),
        .wdata_i(ex_mem_store), .rdata_o(mem_rdata));

    // MEM/WB
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_wb_reg_write  <= 1'b0;
            mem_wb_mem_to_reg <= 1'b0;
            mem_wb_alu        <= '0;
            mem_wb_load       <= '0;
            mem_wb_dest       <= '0;
        end else begin
            mem_wb_reg_write  <= ex_mem_reg_write;
            mem_wb_mem_to_reg <= ex_mem_mem_to_reg;
            mem_wb_alu        <= ex_mem_alu;
            mem_wb_load       <= ex_mem_mem_read ? mem_rdata : 32'd0;
            mem_wb_dest       <= ex_mem_dest;
        end
    end

    assign wb_data = mem_wb_mem_to_reg ? mem_wb_load : mem_wb_alu;
endmodule

// File: tb/tb_pipeline_cpu.sv
// Directed bench for pipeline_cpu: small programs preloaded hierarchically,
// results checked against hand-computed values.
module tb_pipeline_cpu;
    logic clk_i = 1'b0;
    logic rst_i;
    logic start_i;
    int unsigned total     = 0;
    int unsigned passed    = 0;
    int unsigned stall_cnt = 0;
    int unsigned flush_cnt = 0;

    pipeline_cpu dut (.clk_i(clk_i), .rst_i(rst_i), .start_i(start_i));

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] addr);
        return {6'h02, addr};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
    endtask

    task automatic clear_state();
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'd0;
        for (int i = 0; i < 32; i++)  dut.Registers.register[i] = 32'd0;
        for (int i = 0; i < 32; i++)  dut.Data_Memory.memory[i] = 8'd0;
    endtask

    // one clock; observe at the falling edge and tally stall/flush cycles
    task automatic tick();
        @(negedge clk_i);
        stall_cnt += 32'(dut.HD_Unit.data_o);
        flush_cnt += 32'(dut.flush);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic restart();
        rst_i   = 1'b1;
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        clear_state();
        stall_cnt = 0;
        flush_cnt = 0;
    endtask

    task automatic go();
        rst_i   = 1'b0;
        start_i = 1'b1;
    endtask

    initial begin
        // reset and start
        rst_i   = 1'b1;
        start_i = 1'b0;
        clear_state();
        @(negedge clk_i);
        check("reset_pc", dut.PC.pc_o, 32'd0);
        check("reset_stall", 32'(dut.HD_Unit.data_o), 32'd0);
        check("reset_flush", 32'(dut.flush), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("pc_hold_start_low", dut.PC.pc_o, 32'd0);
        start_i = 1'b1;
        tick(); check("pc_step1", dut.PC.pc_o, 32'd4);
        tick(); check("pc_step2", dut.PC.pc_o, 32'd8);
        tick(); check("pc_step3", dut.PC.pc_o, 32'd12);

        // load-use: one stall, forwarded load data
        restart();
        dut.Data_Memory.memory[0] = 8'd5;
        dut.Instruction_Memory.memory[0] = enc_i(6'h23, 5'd0, 5'd8, 16'd0);
        dut.Instruction_Memory.memory[1] = enc_r(5'd8, 5'd8, 5'd9, 6'h20);
        go();
        run(12);
        check("lu_r8", dut.Registers.register[8], 32'd5);
        check("lu_r9", dut.Registers.register[9], 32'd10);
        check("lu_stalls", stall_cnt, 32'd1);
        check("lu_flushes", flush_cnt, 32'd0);

        // back-to-back ALU forwarding
        restart();
        dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd3);
        dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd1, 5'd2, 16'd4);
        dut.Instruction_Memory.memory[2] = enc_r(5'd2, 5'd1, 5'd3, 6'h22);
        go();
        run(12);
        check("fw_r1", dut.Registers.register[1], 32'd3);
        check("fw_r2", dut.Registers.register[2], 32'd7);
        check("fw_r3", dut.Registers.register[3], 32'd4);
        check("fw_stalls", stall_cnt, 32'd0);
        check("fw_flushes", flush_cnt, 32'd0);

        // mul then store of the forwarded product
        restart();
        dut.Instruction_Memory.memory[0] = enc_i(6'h08, 5'd0, 5'd4, 16'd6);
        dut.Instruction_Memory.memory[1] = enc_r(5'd4, 5'd4, 5'd5, 6'h18);
        dut.Instruction_Memory.memory[2] = enc_i(6'h2B, 5'd0, 5'd5, 16'd4);
        go();
        run(12);
        check("sm_r4", dut.Registers.register[4], 32'd6);
        check("sm_r5", dut.Registers.register[5], 32'd36);
        check("sm_word4", {dut.Data_Memory.memory[7], dut.Data_Memory.memory[6],
                           dut.Data_Memory.memory[5], dut.Data_Memory.memory[4]}, 32'd36);

        // taken beq skips one instruction
        restart();
        dut.Instruction_Memory.memory[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd1);
        dut.Instruction_Memory.memory[1] = enc_i(6'h08, 5'd0, 5'd6, 16'd1);
        dut.Instruction_Memory.memory[2] = enc_i(6'h08, 5'd0, 5'd7, 16'd2);
        go();
        tick();
        check("beq_flush", 32'(dut.flush), 32'd1);
        check("beq_isbranch", 32'(dut.Control.IsBranch_o), 32'd1);
        run(10);
        check("beq_r6", dut.Registers.register[6], 32'd0);
        check("beq_r7", dut.Registers.register[7], 32'd2);
        check("beq_flushes", flush_cnt, 32'd1);

        // jump to word 10; the slot after j is squashed
        restart();
        dut.Instruction_Memory.memory[0]  = enc_j(26'd10);
        dut.Instruction_Memory.memory[1]  = enc_i(6'h08, 5'd0, 5'd11, 16'd1);
        dut.Instruction_Memory.memory[10] = enc_i(6'h08, 5'd0, 5'd10, 16'd9);
        go();
        tick();
        check("j_flush", 32'(dut.flush), 32'd1);
        check("j_isjump", 32'(dut.Control.IsJump_o), 32'd1);
        check("j_pc_before", dut.PC.pc_o, 32'd4);
        tick();
        check("j_pc_target", dut.PC.pc_o, 32'd40);
        tick();
        check("j_pc_next", dut.PC.pc_o, 32'd44);
        run(8);
        check("j_r10", dut.Registers.register[10], 32'd9);
        check("j_r11", dut.Registers.register[11], 32'd0);
        check("j_flushes", flush_cnt, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipeline_cpu.md
Name: pipeline_cpu

Overview:
- Five-stage in-order 32-bit MIPS-subset CPU: IF, ID, EX, MEM, WB.
- Contains its own instruction memory, data memory and register file; it is the top of the processor design.
- Provides hazard detection (load-use stall), EX forwarding, and branch/jump resolution in ID with a one-slot flush.
- Memories and register file are preloaded hierarchically by the bench; the core has no external bus.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 32-bit words
- DMEM_BYTES, 32, data memory depth in bytes
- NUM_REGS, 32, general-purpose register count

Ports:
- clk_i  input  1  single clock; all state updates on rising edge
- rst_i  input  1  reset, synchronous and active-high
- start_i  input  1  run enable; PC advances only while high

Behaviour:
- Hierarchy names are fixed for bench observation:
  - Instruction_Memory.memory[0..255], 32-bit words
  - Data_Memory.memory[0..31], bytes
  - Registers.register[0..31]
  - PC.pc_o
  - HD_Unit.data_o, stall request
  - Control.IsJump_o and Control.IsBranch_o
  - top-level wire flush
- Reset (rst_i=1 at clock edge):
  - pc_o=0
  - all pipeline registers cleared to NOP (all control bits 0)
  - flush=0, data_o=0
  - memories and register file are NOT cleared.
- PC:
  - Byte address; instruction fetched from memory[pc>>2].
  - pc_o holds when start_i=0 or a stall is active; otherwise it loads next-PC each cycle.
- ISA, standard MIPS encodings:
  - R-type, opcode 0x00, funct: add 0x20, sub 0x22, and 0x24, or 0x25, mul 0x18 (low 32 bits of product).
  - I-type: addi 0x08 (sign-extended imm), lw 0x23, sw 0x2B, beq 0x04.
  - J-type: j 0x02.
  - The all-zero word is a NOP. Other opcodes also execute as NOP.
- Register file:
  - Two read ports and one write port; r0 reads 0 and ignores writes.
  - A WB write to the register being read in ID in the same cycle is bypassed, so ID sees the new value.
- Data memory:
  - Little-endian byte array; lw/sw access the word at {mem[a+3],mem[a+2],mem[a+1],mem[a]}, with a = rs + sext(imm).
  - Addresses are word-aligned; the address is taken modulo 32.
  - Writes occur at the clock edge in MEM; reads are combinational.
- Forwarding to EX operands:
  - EX/MEM result has priority over MEM/WB.
  - Forward only when the writing stage has RegWrite=1 and a nonzero destination equal to the source register.
  - MEM/WB forwards load data for lw, otherwise the ALU result.
- Hazard detection (HD_Unit): data_o=1 when the instruction in EX is lw and its rt equals rs or rt of the instruction in ID. Effect:
  - PC and IF/ID hold.
  - A bubble is inserted into ID/EX.
  - Exactly one stall cycle per load-use.
- Branch/jump, resolved in ID:
  - beq compares the register values read in ID; a taken target is PC+4 + (sext(imm)<<2).
  - j target = {PC+4[31:28], addr26, 2'b00}.
  - On a taken beq or any j, flush=1 for that cycle: next PC = target and the IF/ID register is cleared to NOP.
  - No branch prediction beyond predict-not-taken.
- Control.IsBranch_o=1 for beq and IsJump_o=1 for j, both decoded in ID.
- Priority: reset > stall > flush > normal advance. If stall and flush coincide, the stall wins and the branch re-evaluates next cycle.
- Register write occurs in WB at the clock edge. Instruction latency is 5 cycles from fetch to write.

Test Plan:
- Reset and start: rst_i=1 for one edge, start_i=0 → pc_o stays 0; raise start_i → pc_o = 4, 8, 12 on successive cycles.
- Load-use: mem[0]=5; `lw r8,0(r0)`; `add r9,r8,r8` → r8=5, r9=10, exactly one cycle with data_o=1.
- Forwarding: `addi r1,r0,3`; `addi r2,r1,4`; `sub r3,r2,r1` → r2=7, r3=4, no stall, no flush.
- Store and mul: `addi r4,r0,6`; `mul r5,r4,r4`; `sw r5,4(r0)` → r5=36, word at 0x04 = 36.
- Taken beq: `beq r0,r0,+1`; `addi r6,r0,1`; `addi r7,r0,2` → r6=0, r7=2, flush counted once.
- Jump: `j` to word 10, where word 10 holds `addi r10,r0,9` and the following slot holds `addi r11,r0,1` → r10=9, r11=0, one flush; pc_o continues from 44.
